// File: rtl/sys_cpu_cpu_debug_mem_arbiter_pkg.sv
// rtl/sys_cpu_cpu_debug_mem_arbiter_pkg.sv - shared types and constants for the debug memory arbiter
package sys_CPU_cpu_debug_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_J_RD = 2'd1;
   localparam logic [1:0] ST_A_RD = 2'd2;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } jop_t;

   localparam int JDO_ADDR_LSB  = 17;
   localparam int JDO_WDATA_LSB = 3;
   localparam int JDO_WDATA_MSB = 34;

   // encoding of the round-robin history bit
   localparam logic LG_AVS  = 1'b0;
   localparam logic LG_JTAG = 1'b1;

endpackage

// File: rtl/sys_cpu_cpu_debug_mem_arbiter_if.sv
// rtl/sys_cpu_cpu_debug_mem_arbiter_if.sv - Avalon debug-memory slave bus
interface sys_cpu_cpu_debug_mem_arbiter_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] avs_address;
   logic              avs_read;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic [3:0]        avs_byteenable;
   logic [31:0]       avs_readdata;
   logic              avs_waitrequest;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      input  avs_readdata, avs_waitrequest
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      output avs_readdata, avs_waitrequest
   );
endinterface

// File: rtl/sys_cpu_cpu_debug_mem_arbiter_rr_arb.sv
// rtl/sys_cpu_cpu_debug_mem_arbiter_rr_arb.sv - two-requester round-robin arbiter (JTAG vs Avalon)
module sys_CPU_cpu_debug_rr_arb
   import sys_CPU_cpu_debug_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_j,
   input  logic req_a,
   input  logic advance,
   output logic gnt_j,
   output logic gnt_a
);

   logic last_grant;

   always_comb begin
      gnt_j = req_j && (!req_a || (last_grant == LG_AVS));
      gnt_a = req_a && !gnt_j;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= LG_AVS;
      end else if (advance && (gnt_j || gnt_a)) begin
         last_grant <= gnt_j ? LG_JTAG : LG_AVS;
      end
   end

endmodule

// File: rtl/sys_cpu_cpu_debug_mem_arbiter.sv
// rtl/sys_cpu_cpu_debug_mem_arbiter.sv - JTAG debug command sequencer sharing the debug RAM with Avalon
module sys_cpu_cpu_debug_mem_arbiter
   import sys_CPU_cpu_debug_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [37:0]       jdo,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   sys_cpu_cpu_debug_mem_arbiter_if.slave avs,
   output logic              ram_en,
   output logic              ram_wren,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [3:0]        ram_byteen,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   logic [1:0]        state;
   logic              pend_valid;
   jop_t              pend_op;
   logic [31:0]       pend_data;
   logic [ADDR_W-1:0] jaddr;
   logic [1:0]        n_strobe;
   logic              busy, accept, err_set, idle;
   logic              req_j, req_a, gnt_j, gnt_a;
   logic              unused_jdo;

   assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

   // a command is outstanding from acceptance until its J_RD cycle has finished
   assign n_strobe = {1'b0, take_action_ocimem_a} + {1'b0, take_no_action_ocimem_a}
                   + {1'b0, take_action_ocimem_b};
   assign busy     = pend_valid || (state == ST_J_RD);
   assign accept   = (n_strobe == 2'd1) && !busy;
   assign err_set  = (n_strobe > 2'd1) || ((n_strobe == 2'd1) && busy);

   assign idle  = (state == ST_IDLE) && !reset;
   assign req_j = idle && pend_valid;
   assign req_a = idle && (avs.avs_read || avs.avs_write);

   sys_CPU_cpu_debug_rr_arb u_arb (
      .clk     (clk),
      .reset   (reset),
      .req_j   (req_j),
      .req_a   (req_a),
      .advance (idle),
      .gnt_j   (gnt_j),
      .gnt_a   (gnt_a)
   );

   always_comb begin
      ram_en     = gnt_j || gnt_a;
      ram_wren   = gnt_j ? (pend_op == OP_WR) : (gnt_a && avs.avs_write);
      ram_addr   = gnt_j ? jaddr : avs.avs_address;
      ram_byteen = gnt_j ? 4'hF : avs.avs_byteenable;
      ram_wdata  = gnt_j ? pend_data : avs.avs_writedata;
   end

   // the Avalon master only sees a transfer complete on its write grant or in A_RD
   assign avs.avs_waitrequest = !((gnt_a && avs.avs_write) || ((state == ST_A_RD) && !reset));
   assign avs.avs_readdata    = ram_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         pend_valid    <= 1'b0;
         pend_op       <= OP_RD;
         pend_data     <= 32'h0;
         jaddr         <= '0;
         MonDReg       <= 32'h0;
         monitor_ready <= 1'b1;
         monitor_error <= 1'b0;
      end else begin
         monitor_ready <= !busy;
         if (err_set) begin
            monitor_error <= 1'b1;
         end else if (accept && take_action_ocimem_a) begin
            monitor_error <= 1'b0;
         end
         if (accept) begin
            pend_valid <= 1'b1;
            pend_op    <= take_action_ocimem_b ? OP_WR : OP_RD;
            pend_data  <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            if (take_action_ocimem_a) begin
               jaddr <= jdo[JDO_ADDR_LSB +: ADDR_W];
            end
         end
         case (state)
            ST_IDLE: begin
               if (gnt_j) begin
                  pend_valid <= 1'b0;
                  if (pend_op == OP_WR) begin
                     jaddr <= jaddr + 1'b1;
                  end else begin
                     state <= ST_J_RD;
                  end
               end else if (gnt_a && !avs.avs_write) begin
                  state <= ST_A_RD;
               end
            end
            ST_J_RD: begin
               MonDReg <= ram_rdata;
               jaddr   <= jaddr + 1'b1;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sys_cpu_cpu_debug_mem_arbiter.sv
// tb/tb_sys_cpu_cpu_debug_mem_arbiter.sv - directed self-checking bench for the debug memory arbiter
module tb_sys_cpu_cpu_debug_mem_arbiter;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              take_action_ocimem_a;
   logic              take_no_action_ocimem_a;
   logic              take_action_ocimem_b;
   logic [37:0]       jdo;
   logic [31:0]       MonDReg;
   logic              monitor_ready;
   logic              monitor_error;
   logic              ram_en;
   logic              ram_wren;
   logic [ADDR_W-1:0] ram_addr;
   logic [3:0]        ram_byteen;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
   logic [31:0]       mem [256];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sys_cpu_cpu_debug_mem_arbiter_if #(.ADDR_W(ADDR_W)) avs ();

   sys_cpu_cpu_debug_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .jdo                     (jdo),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error),
      .avs                     (avs),
      .ram_en                  (ram_en),
      .ram_wren                (ram_wren),
      .ram_addr                (ram_addr),
      .ram_byteen              (ram_byteen),
      .ram_wdata               (ram_wdata),
      .ram_rdata               (ram_rdata)
   );

   // single-port RAM with one-cycle read latency and byte enables
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_wren) begin
            for (int i = 0; i < 4; i++)
               if (ram_byteen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
         end else begin
            ram_rdata <= mem[ram_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [37:0] jdo_addr(input logic [7:0] a);
      return {13'b0, a, 17'b0};
   endfunction

   function automatic logic [37:0] jdo_data(input logic [31:0] d);
      return {3'b0, d, 3'b0};
   endfunction

   // kind: 0 = take_action_ocimem_a, 1 = take_no_action_ocimem_a, 2 = take_action_ocimem_b
   task automatic jtag_op(input int kind, input logic [37:0] d, input logic [7:0] exp_addr,
                          input string tag);
      take_action_ocimem_a    = (kind == 0);
      take_no_action_ocimem_a = (kind == 1);
      take_action_ocimem_b    = (kind == 2);
      jdo = d;
      step();
      take_action_ocimem_a    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      take_action_ocimem_b    = 1'b0;
      @(negedge clk);
      chk({tag, "_en"}, 32'(ram_en), 32'd1);
      chk({tag, "_addr"}, 32'(ram_addr), 32'(exp_addr));
      chk({tag, "_wren"}, 32'(ram_wren), 32'(kind == 2));
      step();
      @(negedge clk);
      chk({tag, "_busy1"}, 32'(monitor_ready), 32'd0);
      step();
      if (kind != 2) begin
         @(negedge clk);
         chk({tag, "_busy2"}, 32'(monitor_ready), 32'd0);
         step();
      end
      @(negedge clk);
      chk({tag, "_ready"}, 32'(monitor_ready), 32'd1);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h00] <= 32'hCAFE0000;
      mem[8'h03] <= 32'h11223344;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'h20202020;
      mem[8'h21] <= 32'h21212121;
      mem[8'h22] <= 32'h22222222;
      mem[8'hFE] <= 32'hFEFEFEFE;
      mem[8'hFF] <= 32'hFFFF0000;
      reset = 1'b1;
      take_action_ocimem_a = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      jdo = '0;
      avs.avs_address = '0;
      avs.avs_read = 1'b0;
      avs.avs_write = 1'b0;
      avs.avs_writedata = 32'h0;
      avs.avs_byteenable = 4'h0;
      step();
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mondreg", MonDReg, 32'h0);
      chk("rst_ready", 32'(monitor_ready), 32'd1);
      chk("rst_error", 32'(monitor_error), 32'd0);
      chk("rst_waitreq", 32'(avs.avs_waitrequest), 32'd1);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      step();

      // load address and read, then auto-increment read
      jtag_op(0, jdo_addr(8'h10), 8'h10, "t1_rd");
      chk("t1_mondreg", MonDReg, 32'hDEADBEEF);
      jtag_op(1, '0, 8'h11, "t1_next");
      chk("t1_next_data", MonDReg, 32'h0);

      // write at the top address, then wrap to 0
      jtag_op(0, jdo_addr(8'hFE), 8'hFE, "t2_rd_fe");
      chk("t2_fe_data", MonDReg, 32'hFEFEFEFE);
      jtag_op(2, jdo_data(32'h12345678), 8'hFF, "t2_wr_ff");
      chk("t2_mem_ff", mem[8'hFF], 32'h12345678);
      jtag_op(1, '0, 8'h00, "t2_wrap");
      chk("t2_wrap_data", MonDReg, 32'hCAFE0000);
      jtag_op(1, '0, 8'h01, "t2_inc");

      // Avalon partial write then read-back
      avs.avs_write = 1'b1;
      avs.avs_address = 8'h03;
      avs.avs_writedata = 32'hA5A5A5A5;
      avs.avs_byteenable = 4'b0011;
      @(negedge clk);
      chk("t3_wr_wait", 32'(avs.avs_waitrequest), 32'd0);
      chk("t3_wr_en", 32'(ram_en), 32'd1);
      chk("t3_wr_be", 32'(ram_byteen), 32'h3);
      step();
      avs.avs_write = 1'b0;
      avs.avs_read = 1'b1;
      @(negedge clk);
      chk("t3_rd_wait1", 32'(avs.avs_waitrequest), 32'd1);
      step();
      @(negedge clk);
      chk("t3_rd_wait2", 32'(avs.avs_waitrequest), 32'd0);
      chk("t3_rdata", avs.avs_readdata, 32'h1122A5A5);
      step();
      avs.avs_read = 1'b0;
      @(negedge clk);
      chk("t3_idle_wait", 32'(avs.avs_waitrequest), 32'd1);
      step();

      // first tie after reset goes to JTAG
      reset = 1'b1;
      step();
      reset = 1'b0;
      take_action_ocimem_a = 1'b1;
      jdo = jdo_addr(8'h20);
      step();
      take_action_ocimem_a = 1'b0;
      avs.avs_read = 1'b1;
      avs.avs_address = 8'h21;
      @(negedge clk);
      chk("t4_tie1_addr", 32'(ram_addr), 32'h20);
      chk("t4_tie1_wait", 32'(avs.avs_waitrequest), 32'd1);
      step();
      @(negedge clk);
      chk("t4_jrd_wait", 32'(avs.avs_waitrequest), 32'd1);
      step();
      @(negedge clk);
      chk("t4_a_addr", 32'(ram_addr), 32'h21);
      chk("t4_a_wait", 32'(avs.avs_waitrequest), 32'd1);
      chk("t4_mondreg", MonDReg, 32'h20202020);
      step();
      @(negedge clk);
      chk("t4_ard_wait", 32'(avs.avs_waitrequest), 32'd0);
      chk("t4_ard_data", avs.avs_readdata, 32'h21212121);
      step();
      avs.avs_read = 1'b0;
      jtag_op(2, jdo_data(32'h77777777), 8'h21, "t4_jwr");

      // next tie goes to Avalon
      take_no_action_ocimem_a = 1'b1;
      step();
      take_no_action_ocimem_a = 1'b0;
      avs.avs_read = 1'b1;
      avs.avs_address = 8'h21;
      @(negedge clk);
      chk("t4_tie2_addr", 32'(ram_addr), 32'h21);
      chk("t4_tie2_wren", 32'(ram_wren), 32'd0);
      step();
      @(negedge clk);
      chk("t4_tie2_wait", 32'(avs.avs_waitrequest), 32'd0);
      chk("t4_tie2_data", avs.avs_readdata, 32'h77777777);
      step();
      avs.avs_read = 1'b0;
      @(negedge clk);
      chk("t4_tie2_jaddr", 32'(ram_addr), 32'h22);
      step();
      step();
      @(negedge clk);
      chk("t4_tie2_mondreg", MonDReg, 32'h22222222);
      step();

      // overrun while a command is pending
      take_action_ocimem_a = 1'b1;
      jdo = jdo_addr(8'h10);
      step();
      take_action_ocimem_a = 1'b0;
      take_no_action_ocimem_a = 1'b1;
      @(negedge clk);
      chk("t5_addr", 32'(ram_addr), 32'h10);
      step();
      take_no_action_ocimem_a = 1'b0;
      @(negedge clk);
      chk("t5_err", 32'(monitor_error), 32'd1);
      step();
      @(negedge clk);
      chk("t5_mondreg", MonDReg, 32'hDEADBEEF);
      chk("t5_err_sticky", 32'(monitor_error), 32'd1);
      step();
      @(negedge clk);
      chk("t5_ready", 32'(monitor_ready), 32'd1);
      step();
      jtag_op(0, jdo_addr(8'h30), 8'h30, "t5_clr");
      chk("t5_err_clr", 32'(monitor_error), 32'd0);
      take_action_ocimem_a = 1'b1;
      take_action_ocimem_b = 1'b1;
      jdo = jdo_addr(8'h10);
      step();
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      @(negedge clk);
      chk("t5_dbl_err", 32'(monitor_error), 32'd1);
      chk("t5_dbl_en", 32'(ram_en), 32'd0);
      step();
      @(negedge clk);
      chk("t5_dbl_ready", 32'(monitor_ready), 32'd1);
      step();

      // reset during J_RD
      take_action_ocimem_a = 1'b1;
      jdo = jdo_addr(8'h10);
      step();
      take_action_ocimem_a = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_mondreg", MonDReg, 32'h0);
      chk("t6_ready", 32'(monitor_ready), 32'd1);
      chk("t6_ram_en", 32'(ram_en), 32'd0);
      step();
      @(negedge clk);
      chk("t6_no_stale", MonDReg, 32'h0);
      step();

      // reset during A_RD keeps waitrequest high
      avs.avs_read = 1'b1;
      avs.avs_address = 8'h03;
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("t6_ard_wait", 32'(avs.avs_waitrequest), 32'd1);
      step();
      reset = 1'b0;
      avs.avs_read = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sys_cpu_cpu_debug_mem_arbiter.md
# sys_CPU_cpu_debug_mem_arbiter

Sequences JTAG debug-slave memory commands and shares the single-port on-chip debug RAM between them and the CPU's Avalon debug-memory slave. It turns the sysclk-domain `take_action_ocimem_*` strobes and `jdo` into RAM reads and writes. It returns read data and status through `MonDReg`, `monitor_ready` and `monitor_error`. It arbitrates round-robin against Avalon accesses and stalls Avalon through `avs_waitrequest`.

## Interface
- `ADDR_W`, 8: RAM word-address width. RAM depth is 2^ADDR_W words of 32 bits.
- `clk` in 1: the only clock, the CPU system clock.
- `reset` in 1: synchronous, active-high.
- `take_action_ocimem_a` in 1: one-cycle strobe. Load the JTAG address from `jdo[24:17]` (low ADDR_W bits), then read.
- `take_no_action_ocimem_a` in 1: one-cycle strobe. Read at the current JTAG address, then increment it.
- `take_action_ocimem_b` in 1: one-cycle strobe. Write `jdo[34:3]` to the current JTAG address, then increment it.
- `jdo` in 38: JTAG data register, sampled only in a strobe cycle.
- `MonDReg` out 32: last JTAG read data.
- `monitor_ready` out 1: no JTAG command outstanding.
- `monitor_error` out 1: sticky JTAG overrun flag.
- `avs_address` in ADDR_W: Avalon word address.
- `avs_read` in 1: Avalon read request.
- `avs_write` in 1: Avalon write request.
- `avs_writedata` in 32: Avalon write data.
- `avs_byteenable` in 4: Avalon byte enables.
- `avs_readdata` out 32: equals `ram_rdata`. Valid only while `avs_waitrequest`=0 on a read.
- `avs_waitrequest` out 1: Avalon stall.
- `ram_en` out 1: RAM access enable.
- `ram_wren` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_byteen` out 4: RAM byte enables.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data. Valid in the cycle after a read enable (1-cycle latency).

## Operation
- JTAG pending register:
  - A strobe seen while no JTAG command is pending is latched as pending, with its opcode (RD/WR) and data.
  - `take_action_ocimem_a` loads `jaddr` in the same cycle it is latched.
  - A strobe that arrives while a command is pending or executing is dropped and sets `monitor_error`.
  - Two or more strobes in one cycle is an overrun: latch none, set `monitor_error`.
- `monitor_error` is cleared by an accepted `take_action_ocimem_a`. If a set and a clear occur in the same cycle, set wins.
- `monitor_ready` falls on the cycle after a strobe is accepted. It rises on the cycle after that command completes.
- FSM states:
  - IDLE: on a grant, drive the RAM access.
    - JTAG WR or Avalon write: single cycle, next state IDLE.
    - JTAG RD: next state J_RD.
    - Avalon read: next state A_RD.
  - J_RD: `MonDReg` <= `ram_rdata`, post-increment `jaddr`, then IDLE.
  - A_RD: `avs_waitrequest`=0, `avs_readdata`=`ram_rdata`, then IDLE.
- Arbitration happens only in IDLE.
  - One requester pending: that requester is granted.
  - Both pending: grant the requester not granted last.
  - `last_grant` resets to Avalon, so JTAG wins the first tie.
- `jaddr` post-increments modulo 2^ADDR_W: 255 wraps to 0 with no error.
- JTAG writes use byte enables 4'hF.
- `avs_waitrequest` is 1 except in these cycles:
  - the granted Avalon write cycle;
  - the A_RD cycle.
- When there is no request, `avs_waitrequest` is 1. This is legal because no transfer is requested.
- Avalon requests are not latched. The master holds them stable while `avs_waitrequest`=1.

## Timing
- Reset values:
  - state IDLE, nothing pending, `jaddr` 0, `last_grant` Avalon;
  - `MonDReg` 0, `monitor_ready` 1, `monitor_error` 0;
  - `avs_waitrequest` 1, `ram_en` 0, `ram_wren` 0.
  - The `ram_addr`, `ram_byteen` and `ram_wdata` values do not matter while `ram_en`=0.
- Reset mid-operation: any in-flight read is aborted and no `MonDReg` update occurs. An Avalon read in flight sees waitrequest stay 1.
- JTAG read, uncontended, strobe in cycle t:
  - pending from t+1; RAM read in t+1 (IDLE grant);
  - J_RD in t+2; `MonDReg` valid from t+3;
  - `monitor_ready` is 0 during t+2 and t+3 and returns to 1 at t+4.
- JTAG write, uncontended: RAM write in t+1, `monitor_ready` returns to 1 at t+3.
- Avalon write: 1 cycle when uncontended (waitrequest low in the request cycle).
- Avalon read: 2 cycles when uncontended.
- Worst-case added wait under contention: one JTAG command (2 cycles).
- The JTAG address and data used for a command are those sampled at strobe acceptance. `jdo` may change afterwards.

## Structure
- Package `sys_CPU_cpu_debug_pkg` holds:
  - FSM state enum (IDLE, J_RD, A_RD);
  - JTAG opcode enum (RD, WR);
  - `jdo` field constants: JDO_ADDR_LSB=17, JDO_WDATA_LSB=3, JDO_WDATA_MSB=34.
- Sub-module `sys_CPU_cpu_debug_rr_arb`: 2-requester round-robin arbiter with `last_grant` state and an advance-on-grant input.

## Test plan
- Reset, then `take_action_ocimem_a` with `jdo[24:17]`=8'h10 (RAM[16]=32'hDEADBEEF) -> `MonDReg`=32'hDEADBEEF at t+3, `monitor_ready` back to 1 at t+4, `jaddr`=8'h11.
- Address 8'hFF, `take_action_ocimem_b` with data 32'h12345678, then `take_no_action_ocimem_a` -> RAM[255]=32'h12345678; the read returns RAM[0]; `jaddr`=1.
- Avalon write 32'hA5A5A5A5 with byte enable 4'b0011 to addr 3, then Avalon read of addr 3 -> write waitrequest 0 in the first cycle; read data in the 2nd cycle = 32'hxxxxA5A5 (upper bytes unchanged).
- JTAG read and Avalon read pending in the same IDLE cycle after reset -> JTAG granted first, Avalon waitrequest held 1 for 2 extra cycles; on the next tie Avalon is granted first.
- Second strobe 1 cycle after the first -> `monitor_error`=1 and the first command completes normally. The next `take_action_ocimem_a` clears the error; a strobe coinciding with a new overrun leaves the error at 1.
- `reset` asserted in the J_RD cycle -> `MonDReg`=0, `monitor_ready`=1, `ram_en`=0 from the next cycle, and no stale update afterwards.
